// File: rtl/cache_control_pkg.sv
// Shared types and constants for the L1 cache controller and its datapath.
package lc3b_ctypes;

  typedef enum logic [1:0] {
    IDLE_HIT  = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_ctrl_state_t;

  // 0 selects the pmem fill line, 1 selects the CPU-merged line.
  typedef logic lc3b_cache_inmux_sel;

  localparam logic [1:0] CADDR_CPU = 2'd0;
  localparam logic [1:0] CADDR_WB0 = 2'd1;
  localparam logic [1:0] CADDR_WB1 = 2'd2;

endpackage

// File: rtl/cache_perf_counter.sv
// Wrapping up-counter with synchronous reset, used for cache hit/miss statistics.
module cache_perf_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cache_control.sv
// Sequencing FSM for the two-way write-back, write-allocate L1 cache datapath:
// drives array write enables, mux selects, CPU and pmem handshakes, perf counters.
module cache_control
  import lc3b_ctypes::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  input  logic                hit0,
  input  logic                hit1,
  input  logic                lru_out,
  input  logic                dirty_out0,
  input  logic                dirty_out1,
  output lc3b_cache_inmux_sel inmux_sel,
  output logic                data0_write,
  output logic                data1_write,
  output logic                tag0_write,
  output logic                tag1_write,
  output logic                dirty0_write,
  output logic                dirty1_write,
  output logic                valid0_write,
  output logic                valid1_write,
  output logic                lru_write,
  output logic [1:0]          addrmux_sel,
  output logic [CNT_W-1:0]    perf_hits,
  output logic [CNT_W-1:0]    perf_misses
);

  cache_ctrl_state_t state, state_next;
  logic victim_q;
  logic missed_q;

  logic req;
  logic hit;
  logic victim_dirty;
  logic miss_detect;
  logic hit_count_inc;

  assign req          = mem_read | mem_write;
  assign hit          = hit0 | hit1;
  assign victim_dirty = lru_out ? dirty_out1 : dirty_out0;
  assign miss_detect  = !reset && (state == IDLE_HIT) && req && !hit;
  assign hit_count_inc = mem_resp && !missed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE_HIT;
      victim_q <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state <= state_next;
      if (miss_detect) begin
        victim_q <= lru_out;
        missed_q <= 1'b1;
      end else if (mem_resp) begin
        missed_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE_HIT:  if (req && !hit) state_next = victim_dirty ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (pmem_resp)   state_next = ALLOCATE;
      ALLOCATE:  if (pmem_resp)   state_next = IDLE_HIT;
      default:                    state_next = IDLE_HIT;
    endcase
  end

  // Outputs are gated by reset so an abandoned pmem transaction drops at once.
  always_comb begin
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    inmux_sel    = 1'b0;
    data0_write  = 1'b0;
    data1_write  = 1'b0;
    tag0_write   = 1'b0;
    tag1_write   = 1'b0;
    dirty0_write = 1'b0;
    dirty1_write = 1'b0;
    valid0_write = 1'b0;
    valid1_write = 1'b0;
    lru_write    = 1'b0;
    addrmux_sel  = CADDR_CPU;
    if (!reset) begin
      case (state)
        IDLE_HIT: begin
          if (req && hit) begin
            mem_resp  = 1'b1;
            lru_write = 1'b1;
            if (mem_write) begin
              inmux_sel = 1'b1;
              if (hit0) begin
                data0_write  = 1'b1;
                dirty0_write = 1'b1;
              end else begin
                data1_write  = 1'b1;
                dirty1_write = 1'b1;
              end
            end
          end
        end
        WRITEBACK: begin
          pmem_write  = 1'b1;
          addrmux_sel = victim_q ? CADDR_WB1 : CADDR_WB0;
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          addrmux_sel = CADDR_CPU;
          if (pmem_resp) begin
            if (victim_q) begin
              data1_write  = 1'b1;
              tag1_write   = 1'b1;
              valid1_write = 1'b1;
              dirty1_write = 1'b1;
            end else begin
              data0_write  = 1'b1;
              tag0_write   = 1'b1;
              valid0_write = 1'b1;
              dirty0_write = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  cache_perf_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_count_inc),
    .count (perf_hits)
  );

  cache_perf_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_detect),
    .count (perf_misses)
  );

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: a transaction-level 2-way cache model
// supplies datapath status and predicts every handshake, enable and counter value.
module tb_cache_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_read, mem_write, pmem_resp;
  logic       hit0, hit1, lru_out, dirty_out0, dirty_out1;
  logic       mem_resp, pmem_read, pmem_write, inmux_sel;
  logic       data0_write, data1_write, tag0_write, tag1_write;
  logic       dirty0_write, dirty1_write, valid0_write, valid1_write, lru_write;
  logic [1:0] addrmux_sel;
  logic [3:0] perf_hits, perf_misses;
  logic [8:0] en;

  cache_control #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit0(hit0), .hit1(hit1), .lru_out(lru_out),
    .dirty_out0(dirty_out0), .dirty_out1(dirty_out1), .inmux_sel(inmux_sel),
    .data0_write(data0_write), .data1_write(data1_write),
    .tag0_write(tag0_write), .tag1_write(tag1_write),
    .dirty0_write(dirty0_write), .dirty1_write(dirty1_write),
    .valid0_write(valid0_write), .valid1_write(valid1_write),
    .lru_write(lru_write), .addrmux_sel(addrmux_sel),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  always #5 clk = ~clk;

  assign en = {data0_write, data1_write, tag0_write, tag1_write,
               dirty0_write, dirty1_write, valid0_write, valid1_write, lru_write};

  // Reference cache state: tag [15:6], set [5:4], 4 sets x 2 ways.
  logic [9:0] m_tag   [2][4];
  bit         m_valid [2][4];
  bit         m_dirty [2][4];
  bit         m_lru   [4];
  int unsigned exp_hits, exp_misses;
  bit          exp_missed;
  int unsigned checks, errors;

  function automatic logic [8:0] fill_vec(input bit v);
    return v ? 9'b010101010 : 9'b101010100;
  endfunction

  function automatic logic [8:0] hit_vec(input bit w, input bit wr);
    logic [8:0] e;
    e = 9'b000000001;
    if (wr) e = e | (w ? 9'b010001000 : 9'b100010000);
    return e;
  endfunction

  task automatic drive_status(input logic [15:0] a);
    int unsigned s;
    s = int'(a[5:4]);
    hit0       = m_valid[0][s] && (m_tag[0][s] == a[15:6]);
    hit1       = m_valid[1][s] && (m_tag[1][s] == a[15:6]);
    lru_out    = m_lru[s];
    dirty_out0 = m_dirty[0][s];
    dirty_out1 = m_dirty[1][s];
  endtask

  task automatic clear_model();
    for (int unsigned w = 0; w < 2; w++)
      for (int unsigned s = 0; s < 4; s++) begin
        m_tag[w][s] = '0; m_valid[w][s] = 0; m_dirty[w][s] = 0;
      end
    for (int unsigned s = 0; s < 4; s++) m_lru[s] = 0;
  endtask

  // One CPU request, checked cycle by cycle; drop_at>0 withdraws it in that fill cycle.
  task automatic do_req(input logic [15:0] a, input bit rd, input bit wr,
                        input int unsigned n, input int unsigned m,
                        input int unsigned drop_at);
    int unsigned s;
    bit v, w, dropped;
    logic [8:0] exp_en;
    s = int'(a[5:4]);
    dropped = 0;
    if (!((m_valid[0][s] && m_tag[0][s] == a[15:6]) ||
          (m_valid[1][s] && m_tag[1][s] == a[15:6]))) begin
      v = m_lru[s];
      @(negedge clk); mem_read = rd; mem_write = wr; pmem_resp = 0; drive_status(a); #1;
      checks++;
      if ({mem_resp, pmem_read, pmem_write, en} !== 12'd0) begin
        errors++;
        $display("FAIL miss_detect addr=%h got resp/pr/pw/en=%b%b%b/%b want all 0",
                 a, mem_resp, pmem_read, pmem_write, en);
      end
      exp_misses++;
      exp_missed = 1;
      if (m_dirty[v][s]) begin
        for (int unsigned k = 1; k <= m; k++) begin
          @(negedge clk); pmem_resp = (k == m); drive_status(a); #1;
          checks++;
          if ({pmem_write, pmem_read, addrmux_sel, en, mem_resp} !==
              {1'b1, 1'b0, (v ? 2'd2 : 2'd1), 9'd0, 1'b0}) begin
            errors++;
            $display("FAIL writeback addr=%h cyc=%0d got pw=%b pr=%b amux=%0d en=%b resp=%b want pw=1 pr=0 amux=%0d en=0 resp=0",
                     a, k, pmem_write, pmem_read, addrmux_sel, en, mem_resp, v ? 2 : 1);
          end
        end
      end
      for (int unsigned k = 1; k <= n; k++) begin
        @(negedge clk);
        if (drop_at == k) begin mem_read = 0; mem_write = 0; dropped = 1; end
        pmem_resp = (k == n); drive_status(a); #1;
        exp_en = (k == n) ? fill_vec(v) : 9'd0;
        checks++;
        if ({pmem_read, pmem_write, addrmux_sel, en, inmux_sel, mem_resp} !==
            {1'b1, 1'b0, 2'd0, exp_en, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL allocate addr=%h cyc=%0d got pr=%b pw=%b amux=%0d en=%b inmux=%b resp=%b want pr=1 pw=0 amux=0 en=%b inmux=0 resp=0",
                   a, k, pmem_read, pmem_write, addrmux_sel, en, inmux_sel, mem_resp, exp_en);
        end
      end
      m_tag[v][s]   = a[15:6];
      m_valid[v][s] = 1;
      m_dirty[v][s] = dropped ? 1'b0 : wr;
    end
    if (!dropped) begin
      w = !(m_valid[0][s] && m_tag[0][s] == a[15:6]);
      @(negedge clk); mem_read = rd; mem_write = wr; pmem_resp = 0; drive_status(a); #1;
      checks++;
      if ({mem_resp, pmem_read, pmem_write, en, inmux_sel} !==
          {1'b1, 1'b0, 1'b0, hit_vec(w, wr), wr}) begin
        errors++;
        $display("FAIL hit addr=%h way=%0d wr=%b got resp=%b pr=%b pw=%b en=%b inmux=%b want resp=1 en=%b inmux=%b",
                 a, w, wr, mem_resp, pmem_read, pmem_write, en, inmux_sel, hit_vec(w, wr), wr);
      end
      if (!exp_missed) exp_hits++;
      exp_missed = 0;
      m_lru[s] = (w == 0);
      if (wr) m_dirty[w][s] = 1;
    end
    @(negedge clk); mem_read = 0; mem_write = 0; pmem_resp = 0; drive_status(a); #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, en} !== 12'd0) begin
      errors++;
      $display("FAIL idle_after addr=%h got resp=%b pr=%b pw=%b en=%b want all 0",
               a, mem_resp, pmem_read, pmem_write, en);
    end
    checks++;
    if (perf_hits !== 4'(exp_hits) || perf_misses !== 4'(exp_misses)) begin
      errors++;
      $display("FAIL counters addr=%h got hits=%0d misses=%0d want hits=%0d misses=%0d",
               a, perf_hits, perf_misses, 4'(exp_hits), 4'(exp_misses));
    end
  endtask

  task automatic test_reset();
    reset = 1; mem_read = 1; mem_write = 1; pmem_resp = 1;
    hit0 = 1; hit1 = 0; lru_out = 0; dirty_out0 = 1; dirty_out1 = 1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_resp, pmem_read, pmem_write, inmux_sel, en, addrmux_sel, perf_hits, perf_misses} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs got resp=%b pr=%b pw=%b inmux=%b en=%b amux=%0d hits=%0d misses=%0d want all 0",
               mem_resp, pmem_read, pmem_write, inmux_sel, en, addrmux_sel, perf_hits, perf_misses);
    end
    @(negedge clk); reset = 0; mem_read = 0; mem_write = 0; pmem_resp = 0;
    exp_hits = 0; exp_misses = 0; exp_missed = 0;
  endtask

  task automatic test_read_hit();
    m_tag[0][2] = 10'h048; m_valid[0][2] = 1;
    do_req(16'h1220, 1, 0, 1, 1, 0);
    checks++;
    if (perf_hits !== 4'd1) begin
      errors++;
      $display("FAIL read_hit_count got %0d want 1", perf_hits);
    end
  endtask

  task automatic test_write_hit();
    m_tag[1][3] = 10'h011; m_valid[1][3] = 1; m_lru[3] = 0;
    do_req({10'h011, 2'd3, 4'h4}, 0, 1, 1, 1, 0);
  endtask

  task automatic test_clean_miss();
    do_req({10'h100, 2'd0, 4'h0}, 1, 0, 4, 1, 0);
  endtask

  task automatic test_dirty_miss();
    m_tag[0][1] = 10'h021; m_valid[0][1] = 1; m_dirty[0][1] = 0;
    m_tag[1][1] = 10'h022; m_valid[1][1] = 1; m_dirty[1][1] = 1;
    m_lru[1] = 1;
    do_req({10'h023, 2'd1, 4'h8}, 1, 0, 2, 3, 0);
    checks++;
    if (m_tag[1][1] !== 10'h023 || m_dirty[1][1] !== 1'b0) begin
      errors++;
      $display("FAIL dirty_miss_victim model tag=%h dirty=%b want tag=023 dirty=0",
               m_tag[1][1], m_dirty[1][1]);
    end
  endtask

  task automatic test_reset_mid_writeback();
    logic [15:0] a;
    m_dirty[0][1] = 1; m_lru[1] = 0;
    a = {10'h031, 2'd1, 4'h0};
    @(negedge clk); mem_read = 1; mem_write = 0; pmem_resp = 0; drive_status(a);
    @(negedge clk); drive_status(a); #1;
    checks++;
    if (pmem_write !== 1'b1 || addrmux_sel !== 2'd1) begin
      errors++;
      $display("FAIL rst_wb_entry got pw=%b amux=%0d want pw=1 amux=1", pmem_write, addrmux_sel);
    end
    @(negedge clk); reset = 1; #1;
    checks++;
    if ({pmem_write, pmem_read, addrmux_sel, en, mem_resp} !== 13'd0) begin
      errors++;
      $display("FAIL rst_wb_forced got pw=%b pr=%b amux=%0d en=%b resp=%b want all 0",
               pmem_write, pmem_read, addrmux_sel, en, mem_resp);
    end
    @(negedge clk); reset = 0; mem_read = 0; #1;
    exp_hits = 0; exp_misses = 0; exp_missed = 0;
    checks++;
    if ({pmem_write, pmem_read, perf_hits, perf_misses} !== 10'd0) begin
      errors++;
      $display("FAIL rst_wb_after got pw=%b pr=%b hits=%0d misses=%0d want 0 0 0 0",
               pmem_write, pmem_read, perf_hits, perf_misses);
    end
    do_req(16'h1220, 1, 0, 1, 1, 0);
  endtask

  task automatic test_counter_wrap();
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    exp_hits = 0; exp_misses = 0; exp_missed = 0;
    for (int i = 0; i < 16; i++) do_req(16'h1220, 1, 0, 1, 1, 0);
    checks++;
    if (perf_hits !== 4'd0) begin
      errors++;
      $display("FAIL counter_wrap got hits=%0d want 0", perf_hits);
    end
  endtask

  task automatic test_dropped_request();
    do_req({10'h3f0, 2'd2, 4'h0}, 1, 0, 3, 1, 2);
  endtask

  task automatic test_random();
    logic [15:0] a;
    int unsigned mode;
    for (int i = 0; i < 60; i++) begin
      a = {10'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 4'($urandom)};
      mode = $urandom_range(0, 3);
      do_req(a, mode != 2, mode >= 2, $urandom_range(1, 5), $urandom_range(1, 5), 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    clear_model();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_writeback();
    test_counter_wrap();
    test_dropped_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish within bound");
    $fatal(1);
  end

endmodule
